// File: rtl/if_id_reg.sv
// IF/ID pipeline register: aligns latched fetch PC/valid with the synchronous ROM word,
// keeps decode stable across stalls with a one-entry instruction hold, and bubbles on flush.
module if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ice,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_pc_plus_4,
    input  logic [31:0] inst_i,
    input  logic        stall,
    input  logic        flush,
    output logic        if_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus_4,
    output logic [31:0] id_inst
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q;
    logic        id_valid_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_pc_plus_4_q;
    logic [31:0] hold_inst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            id_valid_q     <= 1'b0;
            id_pc_q        <= RESET_PC;
            id_pc_plus_4_q <= RESET_PC + 32'd4;
            hold_inst_q    <= NOP_INST;
        end else if (flush) begin
            // Redirect: kill the decode slot but leave its PC fields alone.
            id_valid_q <= 1'b0;
            state_q    <= RUN;
        end else if (stall) begin
            // Capture the ROM word only on entry; later cycles show stale inst_i.
            if (state_q == RUN) begin
                hold_inst_q <= inst_i;
                state_q     <= HOLD;
            end
        end else begin
            id_valid_q     <= if_ice;
            id_pc_q        <= if_pc;
            id_pc_plus_4_q <= if_pc_plus_4;
            state_q        <= RUN;
        end
    end

    assign if_stall     = stall & ~flush;
    assign id_valid     = id_valid_q;
    assign id_pc        = id_pc_q;
    assign id_pc_plus_4 = id_pc_plus_4_q;

    always_comb begin
        if (!id_valid_q) begin
            id_inst = NOP_INST;
        end else if (state_q == HOLD) begin
            id_inst = hold_inst_q;
        end else begin
            id_inst = inst_i;
        end
    end

endmodule
